// File: rtl/bomber_status_encoder_pkg.sv
// ---------------------------------------------------------------------------
// bomber_status_encoder_pkg
// Shared definitions for the player-status word. The text-overlay stage
// unpacks the word with these same offsets, so change them here only.
//   - STAT_* : bit offsets/widths of the fields inside the 14-bit status word
//   - AXIS_* : index of the X / Y converter lane
//   - enc_state_t : encoder FSM state encoding
// ---------------------------------------------------------------------------
package bomber_status_encoder_pkg;

    // Status word layout
    localparam int STAT_XT        = 0;   // X tens digit (only bit 0 of the nibble)
    localparam int STAT_XO_LSB    = 1;   // X ones digit, 4 bits
    localparam int STAT_YT        = 5;   // Y tens digit (only bit 0 of the nibble)
    localparam int STAT_YO_LSB    = 6;   // Y ones digit, 4 bits
    localparam int STAT_LIVES_LSB = 10;  // lives, 2 bits
    localparam int STAT_BOMBS_LSB = 12;  // bombs, 2 bits
    localparam int STAT_W         = 14;

    localparam int STAT_DIGIT_W   = 4;
    localparam int STAT_CNT_W     = 2;

    // Converter lanes
    localparam int NUM_AXES = 2;
    localparam int AXIS_X   = 0;
    localparam int AXIS_Y   = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } enc_state_t;

endpackage

// File: rtl/bomber_status_encoder_bin2bcd_serial.sv
// ---------------------------------------------------------------------------
// bin2bcd_serial
// Serial shift-add-3 (double-dabble) binary to two-digit BCD converter.
// One bit is consumed per 'step'; BIN_WIDTH steps after 'load' the digits
// on tens/ones are final. Digits hold until the next load.
// Ports:
//   i_pclk, i_rst : clock, synchronous active-high reset
//   load          : capture din and clear the BCD accumulator
//   din           : binary value to convert
//   step          : perform one adjust+shift iteration
//   tens, ones    : BCD digits (valid after BIN_WIDTH steps)
// ---------------------------------------------------------------------------
module bin2bcd_serial #(
    parameter int BIN_WIDTH = 5
) (
    input  logic                 i_pclk,
    input  logic                 i_rst,
    input  logic                 load,
    input  logic [BIN_WIDTH-1:0] din,
    input  logic                 step,
    output logic [3:0]           tens,
    output logic [3:0]           ones
);

    logic [BIN_WIDTH-1:0] shift_q;
    logic [7:0]           bcd_q;
    logic [7:0]           bcd_adj;
    logic                 unused_adj_msb;

    // Add 3 to any nibble >= 5 so the following shift carries correctly
    // into the next decimal digit.
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    end

    // Inputs never exceed two digits, so the top bit is shifted out unused.
    assign unused_adj_msb = bcd_adj[7];

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            shift_q <= '0;
            bcd_q   <= '0;
        end else if (load) begin
            shift_q <= din;
            bcd_q   <= '0;
        end else if (step) begin
            bcd_q   <= {bcd_adj[6:0], shift_q[BIN_WIDTH-1]};
            shift_q <= shift_q << 1;
        end
    end

    assign tens = bcd_q[7:4];
    assign ones = bcd_q[3:0];

endmodule

// File: rtl/bomber_status_encoder.sv
// ---------------------------------------------------------------------------
// bomber_status_encoder
// Builds the packed player-status word for the text overlay. On each vsync
// rising edge the raw player state is sampled (positions clamped to their
// maxima), X/Y are converted to BCD serially, and the whole word is then
// written in a single cycle so the overlay never sees a mixed frame.
// Ports:
//   i_pclk, i_rst   : pixel clock, synchronous active-high reset
//   i_vsync         : frame sync, rising edge starts a sample
//   i_pos_x/i_pos_y : binary grid position
//   i_lives/i_bombs : 2-bit counters, passed through
//   o_status_data   : registered status word, holds between commits
//   o_valid         : one-cycle pulse when o_status_data was just written
//   o_busy          : sample/conversion in flight (edges ignored meanwhile)
// ---------------------------------------------------------------------------
module bomber_status_encoder
    import bomber_status_encoder_pkg::*;
#(
    parameter int BIN_WIDTH = 5,
    parameter int X_MAX_VAL = 19,
    parameter int Y_MAX_VAL = 19
) (
    input  logic                 i_pclk,
    input  logic                 i_rst,
    input  logic                 i_vsync,
    input  logic [BIN_WIDTH-1:0] i_pos_x,
    input  logic [BIN_WIDTH-1:0] i_pos_y,
    input  logic [1:0]           i_lives,
    input  logic [1:0]           i_bombs,
    output logic [STAT_W-1:0]    o_status_data,
    output logic                 o_valid,
    output logic                 o_busy
);

    localparam int                   ITER_W    = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [ITER_W-1:0]    ITER_LAST = ITER_W'(BIN_WIDTH - 1);
    localparam logic [BIN_WIDTH-1:0] X_MAX     = BIN_WIDTH'(X_MAX_VAL);
    localparam logic [BIN_WIDTH-1:0] Y_MAX     = BIN_WIDTH'(Y_MAX_VAL);

    enc_state_t state, state_nxt;

    logic                  vsync_q;
    logic                  vs_edge;
    logic                  load;
    logic                  step;
    logic                  commit;
    logic [ITER_W-1:0]     iter;
    logic [STAT_CNT_W-1:0] lives_q;
    logic [STAT_CNT_W-1:0] bombs_q;
    logic [STAT_W-1:0]     status_nxt;

    logic [NUM_AXES-1:0][BIN_WIDTH-1:0]    din;
    logic [NUM_AXES-1:0][STAT_DIGIT_W-1:0] tens;
    logic [NUM_AXES-1:0][STAT_DIGIT_W-1:0] ones;
    logic                                  unused_tens_hi;

    assign vs_edge = i_vsync & ~vsync_q;

    // Clamp before conversion; the packed tens digit is only one bit wide.
    assign din[AXIS_X] = (i_pos_x > X_MAX) ? X_MAX : i_pos_x;
    assign din[AXIS_Y] = (i_pos_y > Y_MAX) ? Y_MAX : i_pos_y;

    // -----------------------------------------------------------------------
    // Converter lanes (X, Y); the shift register inside each lane doubles as
    // the position shadow, so later input changes cannot leak in.
    // -----------------------------------------------------------------------
    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        bin2bcd_serial #(
            .BIN_WIDTH (BIN_WIDTH)
        ) u_b2b (
            .i_pclk (i_pclk),
            .i_rst  (i_rst),
            .load   (load),
            .din    (din[a]),
            .step   (step),
            .tens   (tens[a]),
            .ones   (ones[a])
        );
    end

    assign unused_tens_hi = ^{tens[AXIS_X][3:1], tens[AXIS_Y][3:1]};

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge i_pclk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (vs_edge) begin
                    load      = 1'b1;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                step = 1'b1;
                if (iter == ITER_LAST) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Busy covers CONVERT and COMMIT; it falls the same cycle o_valid rises.
    assign o_busy = (state != IDLE);

    // -----------------------------------------------------------------------
    // Status word assembly
    // -----------------------------------------------------------------------
    always_comb begin
        status_nxt                                   = '0;
        status_nxt[STAT_XT]                          = tens[AXIS_X][0];
        status_nxt[STAT_XO_LSB +: STAT_DIGIT_W]      = ones[AXIS_X];
        status_nxt[STAT_YT]                          = tens[AXIS_Y][0];
        status_nxt[STAT_YO_LSB +: STAT_DIGIT_W]      = ones[AXIS_Y];
        status_nxt[STAT_LIVES_LSB +: STAT_CNT_W]     = lives_q;
        status_nxt[STAT_BOMBS_LSB +: STAT_CNT_W]     = bombs_q;
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            vsync_q       <= 1'b0;
            iter          <= '0;
            lives_q       <= '0;
            bombs_q       <= '0;
            o_status_data <= '0;
            o_valid       <= 1'b0;
        end else begin
            vsync_q <= i_vsync;
            o_valid <= commit;
            if (load) begin
                iter    <= '0;
                lives_q <= i_lives;
                bombs_q <= i_bombs;
            end else if (step) begin
                iter <= iter + 1'b1;
            end
            if (commit) o_status_data <= status_nxt;
        end
    end

endmodule

// File: tb/tb_bomber_status_encoder.sv
// ---------------------------------------------------------------------------
// tb_bomber_status_encoder
// Directed bench for bomber_status_encoder with hand-computed expectations
// and a small decimal reference for the position sweep.
// ---------------------------------------------------------------------------
module tb_bomber_status_encoder;

    logic        i_pclk = 1'b0;
    logic        i_rst;
    logic        i_vsync;
    logic [4:0]  i_pos_x;
    logic [4:0]  i_pos_y;
    logic [1:0]  i_lives;
    logic [1:0]  i_bombs;
    logic [13:0] o_status_data;
    logic        o_valid;
    logic        o_busy;

    int n_chk  = 0;
    int n_fail = 0;

    bomber_status_encoder dut (
        .i_pclk        (i_pclk),
        .i_rst         (i_rst),
        .i_vsync       (i_vsync),
        .i_pos_x       (i_pos_x),
        .i_pos_y       (i_pos_y),
        .i_lives       (i_lives),
        .i_bombs       (i_bombs),
        .o_status_data (o_status_data),
        .o_valid       (o_valid),
        .o_busy        (o_busy)
    );

    always #5 i_pclk = ~i_pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge i_pclk);
        #1;
    endtask

    // Independent reference: clamp, decimal split, pack at the documented offsets.
    function automatic logic [13:0] ref_word(input int x, input int y, input int l, input int b);
        int cx, cy;
        logic [13:0] w;
        cx = (x > 19) ? 19 : x;
        cy = (y > 19) ? 19 : y;
        w = '0;
        w[0]     = 1'((cx / 10) & 1);
        w[4:1]   = 4'(cx % 10);
        w[5]     = 1'((cy / 10) & 1);
        w[9:6]   = 4'(cy % 10);
        w[11:10] = 2'(l);
        w[13:12] = 2'(b);
        return w;
    endfunction

    // One full frame: edge in cycle n, busy n+1..n+6, valid/data in n+7.
    task automatic run_frame(input string tag, input logic [4:0] x, input logic [4:0] y,
                             input logic [1:0] l, input logic [1:0] b, input logic [13:0] exp);
        i_vsync = 1'b0;
        tick();
        i_pos_x = x; i_pos_y = y; i_lives = l; i_bombs = b;
        i_vsync = 1'b1;
        tick();
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("%s busy n+%0d", tag, k), o_busy, 1);
            check($sformatf("%s valid n+%0d", tag, k), o_valid, 0);
            tick();
        end
        check({tag, " valid n+7"}, o_valid, 1);
        check({tag, " busy n+7"}, o_busy, 0);
        check({tag, " data"}, o_status_data, exp);
        tick();
        check({tag, " valid n+8"}, o_valid, 0);
        i_vsync = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [13:0] held;

        i_rst = 1'b1; i_vsync = 1'b0;
        i_pos_x = '0; i_pos_y = '0; i_lives = '0; i_bombs = '0;
        tick(); tick();
        check("reset data", o_status_data, 0);
        check("reset valid", o_valid, 0);
        check("reset busy", o_busy, 0);
        i_rst = 1'b0;
        tick();

        // 1: basic frame
        run_frame("t1", 5'd17, 5'd5, 2'd3, 2'd2, 14'h2D4F);
        // Data holds between commits
        tick(); tick();
        check("t1 hold", o_status_data, 14'h2D4F);

        // 2: X saturation, Y tens
        run_frame("t2", 5'd25, 5'd10, 2'd0, 2'd0, 14'h0033);

        // 3: input change and re-edge while busy are ignored
        i_vsync = 1'b0; tick();
        i_pos_x = 5'd3; i_pos_y = 5'd0; i_lives = 2'd0; i_bombs = 2'd0;
        i_vsync = 1'b1; tick();                  // n+1
        tick();                                  // n+2
        i_pos_x = 5'd12; i_vsync = 1'b0; tick(); // n+3
        i_vsync = 1'b1;
        tick(); tick(); tick();                  // n+6
        check("t3 valid n+6", o_valid, 0);
        tick();                                  // n+7
        check("t3 valid n+7", o_valid, 1);
        check("t3 data", o_status_data, 14'h0006);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (o_valid) pulses++;
        end
        check("t3 no retrigger", pulses, 0);
        check("t3 no busy", o_busy, 0);

        // 4: reset mid-conversion
        i_vsync = 1'b0; tick();
        i_pos_x = 5'd17; i_pos_y = 5'd5; i_lives = 2'd3; i_bombs = 2'd2;
        i_vsync = 1'b1; tick();                  // n+1
        tick(); tick();                          // n+3
        i_rst = 1'b1; tick();                    // n+4
        check("t4 rst data", o_status_data, 0);
        check("t4 rst valid", o_valid, 0);
        check("t4 rst busy", o_busy, 0);
        i_rst = 1'b0; i_vsync = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (o_valid || o_busy) pulses++;
        end
        check("t4 aborted", pulses, 0);
        run_frame("t4b", 5'd9, 5'd9, 2'd1, 2'd1, 14'h1652);

        // 5: vsync held high for 100 cycles -> one pulse, data stable
        i_vsync = 1'b0; tick();
        i_pos_x = 5'd0; i_pos_y = 5'd0; i_lives = 2'd2; i_bombs = 2'd3;
        i_vsync = 1'b1;
        pulses = 0;
        held = '0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (o_valid) begin
                pulses++;
                held = o_status_data;
            end
            if (k == 20) begin
                i_pos_x = 5'd7; i_lives = 2'd1;
            end
        end
        check("t5 pulses", pulses, 1);
        check("t5 commit data", held, 14'h3800);
        check("t5 stable", o_status_data, 14'h3800);
        i_vsync = 1'b0; tick();

        // 6: sweep positions 0..31
        for (int v = 0; v < 32; v++) begin
            run_frame($sformatf("t6 v%0d", v), 5'(v), 5'(31 - v), 2'(v), 2'(v >> 2),
                      ref_word(v, 31 - v, v & 3, (v >> 2) & 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
